// File: rtl/mem_defs.sv
// ============================================================================
// mem_defs : shared RAM geometry constants and controller state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_defs;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 64;
    localparam int BYTES      = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_byte_merge.sv
// ============================================================================
// mem_byte_merge : per-byte select between an old and a new word
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_byte_merge
    import mem_defs::*;
#(
    parameter int DATA_WIDTH = mem_defs::DATA_WIDTH
) (
    input  logic [0:DATA_WIDTH-1]   old_i,
    input  logic [0:DATA_WIDTH-1]   new_i,
    input  logic [0:DATA_WIDTH/8-1] byte_en_i,
    output logic [0:DATA_WIDTH-1]   merged_o
);

    // Byte i occupies bits [8i:8i+7]; bit 0 is the MSB of the word.
    for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_byte
        assign merged_o[8*i +: 8] = byte_en_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end

endmodule

`default_nettype wire

// File: rtl/mem_ram_controller.sv
// ============================================================================
// mem_ram_controller : single-request sequencer for a 1-cycle-latency
// single-port RAM, with read-modify-write for partial writes. Rev 1.0
// ============================================================================
`default_nettype none

module mem_ram_controller
    import mem_defs::*;
#(
    parameter int ADDR_WIDTH = mem_defs::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_defs::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [0:DATA_WIDTH-1]   req_wdata,
    input  logic [0:DATA_WIDTH/8-1] req_byte_en,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [0:DATA_WIDTH-1]   resp_rdata,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic                    ram_isReading,
    inout  wire  [0:DATA_WIDTH-1]   ram_data
);

    localparam int NBYTES = DATA_WIDTH / 8;

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic [0:DATA_WIDTH-1]   resp_rdata_q;
    logic [ADDR_WIDTH-1:0]   ram_address_q;
    logic                    ram_isReading_q;
    logic                    write_q;
    logic [0:DATA_WIDTH-1]   wdata_q;
    logic [0:NBYTES-1]       byte_en_q;
    logic [0:DATA_WIDTH-1]   merged_d;

    mem_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_i     (ram_data),
        .new_i     (wdata_q),
        .byte_en_i (byte_en_q),
        .merged_o  (merged_d)
    );

    // The RAM commits on any edge with isReading low, so the bus is only
    // driven in exactly that cycle.
    assign ram_data      = ram_isReading_q ? {DATA_WIDTH{1'bz}} : wdata_q;
    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign ram_address   = ram_address_q;
    assign ram_isReading = ram_isReading_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            ram_address_q   <= '0;
            ram_isReading_q <= 1'b1;
            write_q         <= 1'b0;
            wdata_q         <= '0;
            byte_en_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        wdata_q     <= req_wdata;
                        byte_en_q   <= req_byte_en;
                        req_ready_q <= 1'b0;
                        if (req_write && (&req_byte_en)) begin
                            ram_address_q   <= req_addr;
                            ram_isReading_q <= 1'b0;
                            state_q         <= WRITE;
                        end else if (!req_write || (req_byte_en != '0)) begin
                            ram_address_q <= req_addr;
                            state_q       <= RD_WAIT;
                        end else begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    resp_rdata_q <= ram_data;
                    if (write_q) begin
                        wdata_q         <= merged_d;
                        ram_isReading_q <= 1'b0;
                        state_q         <= WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    ram_isReading_q <= 1'b1;
                    resp_valid_q    <= 1'b1;
                    state_q         <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_ram_controller.sv
// ============================================================================
// tb_mem_ram_controller : vector table plus scoreboard against a behavioural
// 2048 x 64 single-port RAM. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_ram_controller;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [0:DW-1]   req_wdata;
    logic [0:BW-1]   req_byte_en;
    logic            resp_valid;
    logic            resp_ready;
    logic [0:DW-1]   resp_rdata;
    logic [AW-1:0]   ram_address;
    logic            ram_isReading;
    wire  [0:DW-1]   ram_data;

    always #5 clk = ~clk;

    mem_ram_controller dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_byte_en   (req_byte_en),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .ram_address   (ram_address),
        .ram_isReading (ram_isReading),
        .ram_data      (ram_data)
    );

    // Behavioural RAM: writes when isReading is low, registered read data.
    logic [0:DW-1] mem [2048] = '{default: '0};
    logic [0:DW-1] ram_rd_q = '0;
    always @(posedge clk) begin
        if (!ram_isReading) mem[ram_address] <= ram_data;
        ram_rd_q <= mem[ram_address];
    end
    assign ram_data = ram_isReading ? ram_rd_q : {DW{1'bz}};

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [0:DW-1] wdata;
        logic [0:BW-1] be;
        int            lat;
        int            lows;
        int            bp;
        logic [0:DW-1] exp;
    } vec_t;

    vec_t          vecs[9];
    logic [0:DW-1] exp_q[$];
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int            lat;
        int            lows;
        logic [0:DW-1] held;
        logic [0:DW-1] exp;
        @(negedge clk);
        check($sformatf("v%0d req_ready before", idx), {63'd0, req_ready}, 64'd1);
        req_valid   = 1'b1;
        req_write   = v.wr;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_byte_en = v.be;
        resp_ready  = (v.bp == 0);
        @(posedge clk);
        exp_q.push_back(v.exp);
        #1 req_valid = 1'b0;
        lat  = 0;
        lows = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!ram_isReading) begin
                lows++;
                check($sformatf("v%0d ram_address", idx), {53'd0, ram_address}, {53'd0, v.addr});
            end
            if (resp_valid) break;
        end
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d isReading low cycles", idx), lows, v.lows);
        exp = exp_q.pop_front();
        check($sformatf("v%0d resp_rdata", idx), resp_rdata, exp);
        held = resp_rdata;
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            check($sformatf("v%0d bp resp_valid", idx), {63'd0, resp_valid}, 64'd1);
            check($sformatf("v%0d bp rdata", idx), resp_rdata, held);
            check($sformatf("v%0d bp req_ready", idx), {63'd0, req_ready}, 64'd0);
            check($sformatf("v%0d bp isReading", idx), {63'd0, ram_isReading}, 64'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d req_ready after", idx), {63'd0, req_ready}, 64'd1);
        check($sformatf("v%0d resp_valid after", idx), {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        //           wr    addr  wdata                  be     lat lows bp  exp
        vecs[0] = '{1'b1, 11'd5,    64'h0123456789ABCDEF, 8'hFF, 2, 1, 0, 64'h0};
        vecs[1] = '{1'b0, 11'd5,    64'h0,                8'h00, 3, 0, 0, 64'h0123456789ABCDEF};
        vecs[2] = '{1'b1, 11'd5,    64'h00000000000000FF, 8'h01, 4, 1, 0, 64'h0123456789ABCDEF};
        vecs[3] = '{1'b0, 11'd5,    64'h0,                8'hFF, 3, 0, 0, 64'h0123456789ABCDFF};
        vecs[4] = '{1'b0, 11'd2047, 64'h0,                8'h00, 3, 0, 4, 64'h0};
        vecs[5] = '{1'b1, 11'd9,    64'hDEADBEEFDEADBEEF, 8'h00, 1, 0, 0, 64'h0};
        vecs[6] = '{1'b0, 11'd9,    64'h0,                8'h00, 3, 0, 0, 64'h0};
        vecs[7] = '{1'b1, 11'd5,    64'hAA00000000000000, 8'h80, 4, 1, 2, 64'h0123456789ABCDFF};
        vecs[8] = '{1'b0, 11'd5,    64'h0,                8'h00, 3, 0, 0, 64'hAA23456789ABCDFF};

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_byte_en = '0;
        resp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", {63'd0, req_ready}, 64'd1);
        check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset isReading", {63'd0, ram_isReading}, 64'd1);
        check("reset ram_address", {53'd0, ram_address}, 64'd0);
        check("reset resp_rdata", resp_rdata, 64'd0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset while in RD_DATA: request dropped, memory untouched.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 11'd5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst RD_DATA resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst RD_DATA req_ready", {63'd0, req_ready}, 64'd1);
        check("rst RD_DATA isReading", {63'd0, ram_isReading}, 64'd1);
        check("rst RD_DATA resp_rdata", resp_rdata, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst idle resp_valid", {63'd0, resp_valid}, 64'd0);
        end
        check("rst mem unchanged", mem[5], 64'hAA23456789ABCDFF);
        run_vec(9, vecs[8]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
